// File: rtl/conv_window_gen.sv
// Sliding KxK multi-channel window generator over a raster pixel stream.
// K-1 line buffers plus a column shift register feed a single output register.
module conv_window_gen #(
  parameter int INPUT_SIZE     = 5,
  parameter int INPUT_CHANNELS = 3,
  parameter int KERNEL_SIZE    = 3,
  parameter int PX_SIZE        = 8,
  localparam int OUTPUT_SIZE   = INPUT_SIZE - (KERNEL_SIZE - 1),
  localparam int CW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] px_in,
  input  logic px_valid,
  output logic px_ready,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0]
               [INPUT_CHANNELS-1:0][PX_SIZE-1:0] win_out,
  output logic win_valid,
  input  logic win_ready,
  output logic [CW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic win_last
);

  localparam int K = KERNEL_SIZE;
  localparam int N = INPUT_SIZE;

  if (KERNEL_SIZE < 2 || KERNEL_SIZE > INPUT_SIZE) begin : g_bad_k
    $error("conv_window_gen: KERNEL_SIZE must be in [2, INPUT_SIZE]");
  end

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] KM1  = CW'(K - 1);

  localparam logic [0:0] FILL   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  typedef logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] px_t;
  typedef logic [K-1:0][K-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] win_t;
  typedef logic [K-1:0][K-2:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] sr_t;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] in_col_q, in_col_d;
  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;
  logic [CW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  win_t          win_q, win_d;
  win_t          win_new;
  sr_t           sr_q, sr_d;
  px_t           lb_q [K-1][N];
  px_t           lb_d [K-1][N];

  logic px_acc;
  logic win_acc;
  logic load;

  assign px_ready = !win_valid_q || win_ready;
  assign px_acc   = px_valid && px_ready;
  assign win_acc  = win_valid_q && win_ready;
  assign load     = px_acc && (state_q == STREAM) && (in_col_q >= KM1);

  assign win_out   = win_q;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_last  = win_last_q;

  // Candidate window: K-1 older columns plus the column ending at px_in.
  always_comb begin
    win_new = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        win_new[i][j] = sr_q[i][j];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      win_new[i][K-1] = lb_q[i][in_col_q];
    end
    win_new[K-1][K-1] = px_in;
  end

  always_comb begin
    sr_d = sr_q;
    lb_d = lb_q;
    if (px_acc) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          sr_d[i][j] = win_new[i][j+1];
        end
      end
      for (int i = 0; i < K - 2; i++) begin
        lb_d[i][in_col_q] = lb_q[i+1][in_col_q];
      end
      lb_d[K-2][in_col_q] = px_in;
    end
  end

  always_comb begin
    in_row_d = in_row_q;
    in_col_d = in_col_q;
    if (px_acc) begin
      if (in_col_q == LAST) begin
        in_col_d = '0;
        in_row_d = (in_row_q == LAST) ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == FILL):   if (in_row_d >= KM1) state_d = STREAM;
      (state_q == STREAM): if (in_row_d <  KM1) state_d = FILL;
      default:             state_d = FILL;
    endcase
  end

  always_comb begin
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_d       = win_q;
    if (load) begin
      win_valid_d = 1'b1;
      win_last_d  = (in_row_q == LAST) && (in_col_q == LAST);
      win_row_d   = in_row_q - KM1;
      win_col_d   = in_col_q - KM1;
      win_d       = win_new;
    end else if (win_acc) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      in_row_q    <= '0;
      in_col_q    <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_q       <= '0;
      sr_q        <= '0;
      for (int i = 0; i < K - 1; i++) begin
        for (int c = 0; c < N; c++) begin
          lb_q[i][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      in_row_q    <= in_row_d;
      in_col_q    <= in_col_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_q       <= win_d;
      sr_q        <= sr_d;
      lb_q        <= lb_d;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: random handshakes against a frame-level
// window model built directly from the pixel formula.
module tb_conv_window_gen;

  localparam int N  = 5;
  localparam int C  = 3;
  localparam int K  = 3;
  localparam int PX = 8;
  localparam int OS = N - K + 1;
  localparam int CW = 3;

  typedef logic [C-1:0][PX-1:0] px_t;
  typedef logic [K-1:0][K-1:0][C-1:0][PX-1:0] win_t;
  typedef struct {
    win_t d;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic last;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  px_t px_in = '0;
  logic px_valid = 0;
  logic px_ready;
  win_t win_out;
  logic win_valid;
  logic win_ready = 0;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic win_last;

  int vectors = 0;
  int miscompares = 0;
  int nwin, px12_cyc, win1_cyc, b2b_cnt;

  px_t  pix_q[$];
  int   pix_i_q[$];
  exp_t exp_q[$];

  conv_window_gen #(
    .INPUT_SIZE(N), .INPUT_CHANNELS(C),
    .KERNEL_SIZE(K), .PX_SIZE(PX)
  ) dut (
    .clk(clk), .rst(rst),
    .px_in(px_in), .px_valid(px_valid), .px_ready(px_ready),
    .win_out(win_out), .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col), .win_last(win_last)
  );

  always #5 clk = ~clk;

  function automatic logic [PX-1:0] pv(int off, int r, int c, int ch);
    return PX'(off + r * N + c + 32 * ch);
  endfunction

  task automatic push_frame(input int off);
    px_t p;
    exp_t e;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        for (int ch = 0; ch < C; ch++) p[ch] = pv(off, r, c, ch);
        pix_q.push_back(p);
        pix_i_q.push_back(r * N + c);
      end
    end
    for (int r = 0; r < OS; r++) begin
      for (int c = 0; c < OS; c++) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            for (int ch = 0; ch < C; ch++)
              e.d[i][j][ch] = pv(off, r + i, c + j, ch);
        e.row  = CW'(r);
        e.col  = CW'(c);
        e.last = (r == OS - 1) && (c == OS - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    px_valid = 0;
    win_ready = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    pix_q.delete();
    pix_i_q.delete();
    exp_q.delete();
  endtask

  task automatic run(input int limit, input int vp, input int rp,
                     input int stall, input bit b2b);
    int acc, cyc, stall_left, idx;
    bit stalled, prev_ld, wacc, pacc;
    win_t hd;
    logic [CW-1:0] hr, hc, pc;
    logic hl;
    exp_t e;
    acc = 0; cyc = 0; stall_left = 0; stalled = 0; prev_ld = 0;
    nwin = 0; px12_cyc = -1; win1_cyc = -1; b2b_cnt = 0;
    hd = '0; hr = '0; hc = '0; hl = 0; pc = '0;
    while (cyc < 3000) begin
      @(negedge clk);
      if (limit == 0 && pix_q.size() == 0 && exp_q.size() == 0) break;
      if (limit > 0 && acc >= limit) break;
      px_valid = (pix_q.size() > 0) && ($urandom_range(99) < vp);
      px_in = (pix_q.size() > 0) ? pix_q[0] : '0;
      if (stall > 0 && !stalled && win_valid) begin
        stalled = 1;
        stall_left = stall;
      end
      if (stall_left > 0) win_ready = 0;
      else win_ready = ($urandom_range(99) < rp);
      #1;
      if (stall_left > 0) begin
        if (stall_left == stall) begin
          hd = win_out; hr = win_row; hc = win_col; hl = win_last;
        end else begin
          vectors++;
          if (win_valid !== 1'b1 || win_out !== hd || win_row !== hr ||
              win_col !== hc || win_last !== hl) begin
            miscompares++;
            $display("FAIL stall_hold: got v=%0b r=%0d c=%0d l=%0b, need v=1 r=%0d c=%0d l=%0b",
                     win_valid, win_row, win_col, win_last, hr, hc, hl);
          end
        end
        vectors++;
        if (px_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_px_ready: got %0b, need 0", px_ready);
        end
        stall_left--;
      end
      if (b2b && prev_ld) begin
        b2b_cnt++;
        vectors++;
        if (win_valid !== 1'b1 || win_col !== pc + 3'd1) begin
          miscompares++;
          $display("FAIL b2b: got v=%0b col=%0d, need v=1 col=%0d",
                   win_valid, win_col, pc + 3'd1);
        end
      end
      wacc = win_valid && win_ready;
      pacc = px_valid && px_ready;
      if (win1_cyc < 0 && win_valid) win1_cyc = cyc;
      if (wacc) begin
        vectors++;
        nwin++;
        pc = win_col;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_win: got r=%0d c=%0d, need no window", win_row, win_col);
        end else begin
          e = exp_q.pop_front();
          if (win_out !== e.d || win_row !== e.row || win_col !== e.col ||
              win_last !== e.last) begin
            miscompares++;
            $display("FAIL win_cmp: got r=%0d c=%0d l=%0b d=%h, need r=%0d c=%0d l=%0b d=%h",
                     win_row, win_col, win_last, win_out, e.row, e.col, e.last, e.d);
          end
        end
      end
      prev_ld = 0;
      if (pacc) begin
        idx = pix_i_q.pop_front();
        void'(pix_q.pop_front());
        if (idx == 12 && px12_cyc < 0) px12_cyc = cyc;
        prev_ld = wacc && (idx / N >= K - 1) && (idx % N >= K - 1);
        acc++;
      end
      cyc++;
    end
    if (cyc >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got %0d windows left, need 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (win_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_valid: got %0b, need 0", win_valid);
    end
    vectors++;
    if (win_last !== 1'b0 || win_row !== '0 || win_col !== '0) begin
      miscompares++;
      $display("FAIL rst_coord: got l=%0b r=%0d c=%0d, need 0 0 0",
               win_last, win_row, win_col);
    end
    vectors++;
    if (win_out !== '0) begin
      miscompares++;
      $display("FAIL rst_data: got %h, need 0", win_out);
    end
    vectors++;
    if (px_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_px_ready: got %0b, need 1", px_ready);
    end
  endtask

  task automatic check_count(input int need, input string nm);
    vectors++;
    if (nwin !== need) begin
      miscompares++;
      $display("FAIL %s_count: got %0d, need %0d", nm, nwin, need);
    end
  endtask

  task automatic test_basic();
    do_reset();
    push_frame(0);
    run(0, 100, 100, 0, 0);
    check_count(9, "basic");
    vectors++;
    if (win1_cyc !== px12_cyc + 1) begin
      miscompares++;
      $display("FAIL first_latency: got cycle %0d, need %0d", win1_cyc, px12_cyc + 1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    push_frame(0);
    run(0, 100, 100, 10, 0);
    check_count(9, "stall");
  endtask

  task automatic test_random();
    do_reset();
    push_frame(0);
    run(0, 50, 50, 0, 0);
    check_count(9, "random");
  endtask

  task automatic test_two_frames();
    do_reset();
    push_frame(0);
    push_frame(100);
    run(0, 70, 70, 0, 0);
    check_count(18, "two_frames");
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_frame(0);
    run(18, 100, 100, 0, 0);
    win_ready = 0;
    px_valid = 0;
    #1;
    vectors++;
    if (win_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_rst_valid: got %0b, need 1", win_valid);
    end
    #2 rst = 1;
    #1;
    vectors++;
    if (win_valid !== 1'b0 || px_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_rst: got v=%0b rdy=%0b, need v=0 rdy=1", win_valid, px_ready);
    end
    @(negedge clk);
    rst = 0;
    pix_q.delete();
    pix_i_q.delete();
    exp_q.delete();
    push_frame(0);
    run(0, 100, 100, 0, 0);
    check_count(9, "mid_reset");
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_frame(0);
    run(0, 100, 100, 0, 1);
    vectors++;
    if (b2b_cnt !== 6) begin
      miscompares++;
      $display("FAIL b2b_events: got %0d, need 6", b2b_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_two_frames();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
